// File: rtl/ccff_pkg.sv
// Shared types and constants for the configuration flip-flop bitstream loader.
package ccff_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SHIFT,
    ST_DONE
  } loader_state_e;

  localparam logic [15:0] CCFF_CRC_POLY = 16'h1021;
  localparam logic [15:0] CCFF_CRC_INIT = 16'hFFFF;

endpackage

// File: rtl/ccff_bitstream_loader_if.sv
// Byte-stream valid/ready port feeding the loader; master drives data, slave returns ready.
interface ccff_bitstream_loader_if #(
  parameter int DATA_W = 8
) ();

  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);

endinterface

// File: rtl/ccff_crc16.sv
// Bit-serial CRC-16-CCITT (MSB-first, no reflection, no final xor); clr loads the init value.
module ccff_crc16
  import ccff_pkg::*;
(
  input  logic        prog_clk,
  input  logic        prog_reset,
  input  logic        en,
  input  logic        clr,
  input  logic        din,
  output logic [15:0] crc
);

  logic [15:0] r_crc;
  logic        w_fb;

  assign w_fb = r_crc[15] ^ din;
  assign crc  = r_crc;

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      r_crc <= '0;
    end else if (clr) begin
      r_crc <= CCFF_CRC_INIT;
    end else if (en) begin
      r_crc <= {r_crc[14:0], 1'b0} ^ (w_fb ? CCFF_CRC_POLY : 16'h0000);
    end
  end

endmodule

// File: rtl/ccff_bitstream_loader.sv
// Serializes a byte stream MSB-first into a CCFF chain for exactly CHAIN_LEN shift cycles.
// Optional readback signature of the displaced chain contents: `define CCFF_READBACK_CRC_EN.
module ccff_bitstream_loader
  import ccff_pkg::*;
#(
  parameter int CHAIN_LEN = 1024,
  parameter int DATA_W    = 8
) (
  input  logic                     prog_clk,
  input  logic                     prog_reset,
  input  logic                     start,
  input  logic                     abort,
  ccff_bitstream_loader_if.slave   s_bus,
  output logic                     ccff_head,
  output logic                     ccff_shift_en,
  input  logic                     ccff_tail,
  output logic                     busy,
  output logic                     done,
  output logic                     aborted,
  output logic [15:0]              crc
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int NB_W  = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LP_LAST_BIT = CNT_W'(CHAIN_LEN - 1);

  loader_state_e     r_state;
  logic [DATA_W-1:0] r_word;
  logic [NB_W-1:0]   r_nbits;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic              r_ready;
  logic              r_head;
  logic              r_shift_en;
  logic              r_busy;
  logic              r_done;
  logic              r_aborted;
  logic              w_crc_clr;

  assign s_bus.s_ready = r_ready;
  assign ccff_head     = r_head;
  assign ccff_shift_en = r_shift_en;
  assign busy          = r_busy;
  assign done          = r_done;
  assign aborted       = r_aborted;
  assign w_crc_clr     = (r_state == ST_IDLE) && start;

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      r_state    <= ST_IDLE;
      r_word     <= '0;
      r_nbits    <= '0;
      r_bit_cnt  <= '0;
      r_ready    <= 1'b0;
      r_head     <= 1'b0;
      r_shift_en <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_aborted  <= 1'b0;
    end else begin
      r_shift_en <= 1'b0;
      r_done     <= 1'b0;
      r_aborted  <= 1'b0;
      if (abort && (r_state != ST_IDLE)) begin
        r_state   <= ST_IDLE;
        r_ready   <= 1'b0;
        r_busy    <= 1'b0;
        r_aborted <= 1'b1;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start) begin
              r_state   <= ST_FETCH;
              r_bit_cnt <= '0;
              r_ready   <= 1'b1;
              r_busy    <= 1'b1;
            end
          end
          ST_FETCH: begin
            if (s_bus.s_valid) begin
              r_word  <= s_bus.s_data;
              r_nbits <= NB_W'(DATA_W);
              r_ready <= 1'b0;
              r_state <= ST_SHIFT;
            end
          end
          ST_SHIFT: begin
            r_head     <= r_word[DATA_W-1];
            r_shift_en <= 1'b1;
            r_word     <= r_word << 1;
            r_nbits    <= r_nbits - NB_W'(1);
            r_bit_cnt  <= r_bit_cnt + CNT_W'(1);
            // Chain length wins over word boundary: leftover low bits of the last word are dropped.
            if (r_bit_cnt == LP_LAST_BIT) begin
              r_state <= ST_DONE;
              r_busy  <= 1'b0;
            end else if (r_nbits == NB_W'(1)) begin
              r_state <= ST_FETCH;
              r_ready <= 1'b1;
            end
          end
          ST_DONE: begin
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef CCFF_READBACK_CRC_EN
  // Signature of the configuration being displaced: tail is sampled before each shift.
  ccff_crc16 u_crc (
    .prog_clk   (prog_clk),
    .prog_reset (prog_reset),
    .en         (r_shift_en),
    .clr        (w_crc_clr),
    .din        (ccff_tail),
    .crc        (crc)
  );
`else
  logic w_unused_tail;
  assign w_unused_tail = ccff_tail ^ w_crc_clr;
  assign crc           = '0;
`endif

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Self-checking bench: 15-bit chain model driven by the loader, stream/CRC reference model.
module tb_ccff_bitstream_loader;

  localparam int CHAIN_LEN = 15;
  localparam int DATA_W    = 8;
  localparam int BOUND     = 200;

  logic        prog_clk = 1'b0;
  logic        prog_reset;
  logic        start;
  logic        abort;
  logic        ccff_head;
  logic        ccff_shift_en;
  logic        ccff_tail;
  logic        busy;
  logic        done;
  logic        aborted;
  logic [15:0] crc;

  ccff_bitstream_loader_if #(.DATA_W(DATA_W)) bus ();

  ccff_bitstream_loader #(
    .CHAIN_LEN (CHAIN_LEN),
    .DATA_W    (DATA_W)
  ) dut (
    .prog_clk      (prog_clk),
    .prog_reset    (prog_reset),
    .start         (start),
    .abort         (abort),
    .s_bus         (bus),
    .ccff_head     (ccff_head),
    .ccff_shift_en (ccff_shift_en),
    .ccff_tail     (ccff_tail),
    .busy          (busy),
    .done          (done),
    .aborted       (aborted),
    .crc           (crc)
  );

  always #5 prog_clk = ~prog_clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Fabric model: 15-bit chain shifting on edges with shift_en high, plus pulse counters.
  logic [CHAIN_LEN-1:0] chain = '0;
  logic [CHAIN_LEN-1:0] mon_prior;
  logic                 mon_load;
  int                   shift_cnt = 0;
  int                   done_cnt = 0;
  int                   abort_cnt = 0;

  assign ccff_tail = chain[CHAIN_LEN-1];

  always @(posedge prog_clk) begin
    if (mon_load) begin
      chain     <= mon_prior;
      shift_cnt <= 0;
      done_cnt  <= 0;
      abort_cnt <= 0;
    end else begin
      if (ccff_shift_en) begin
        chain     <= {chain[CHAIN_LEN-2:0], ccff_head};
        shift_cnt <= shift_cnt + 1;
      end
      if (done)    done_cnt  <= done_cnt + 1;
      if (aborted) abort_cnt <= abort_cnt + 1;
    end
  end

  // Reference: first CHAIN_LEN stream bits, MSB-first; the first bit ends deepest (bit 14).
  function automatic logic [CHAIN_LEN-1:0] exp_chain(input logic [7:0] b0, input logic [7:0] b1);
    logic stream[$];
    logic [CHAIN_LEN-1:0] r;
    for (int i = 7; i >= 0; i--) stream.push_back(b0[i]);
    for (int i = 7; i >= 0; i--) stream.push_back(b1[i]);
    r = '0;
    for (int k = 0; k < CHAIN_LEN; k++) r[CHAIN_LEN-1-k] = stream[k];
    return r;
  endfunction

  // Reference signature: displaced bits leave the tail deepest-first.
  function automatic logic [15:0] exp_crc(input logic [CHAIN_LEN-1:0] prior);
`ifdef CCFF_READBACK_CRC_EN
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    for (int i = CHAIN_LEN - 1; i >= 0; i--) begin
      fb = c[15] ^ prior[i];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h1021;
    end
    return c;
`else
    return (prior == prior) ? 16'h0000 : 16'hFFFF;
`endif
  endfunction

  task automatic begin_load(input logic [CHAIN_LEN-1:0] prior);
    @(negedge prog_clk);
    mon_load  = 1'b1;
    mon_prior = prior;
    @(negedge prog_clk);
    mon_load = 1'b0;
    start    = 1'b1;
    @(negedge prog_clk);
    start = 1'b0;
  endtask

  // Returns at the negedge after the byte was accepted; counts shift_en highs during the gap.
  task automatic send_byte(input logic [7:0] b, input int gap, input string tag, output int gap_hi);
    int t;
    gap_hi = 0;
    t = 0;
    bus.s_data = b;
    if (gap > 0) bus.s_valid = 1'b0;
    while (!bus.s_ready && t < BOUND) begin
      @(negedge prog_clk);
      t++;
    end
    if (!bus.s_ready) begin
      check({tag, "_ready_timeout"}, 32'd0, 32'd1);
      return;
    end
    for (int g = 0; g < gap; g++) begin
      @(negedge prog_clk);
      if (ccff_shift_en) gap_hi++;
    end
    bus.s_valid = 1'b1;
    @(negedge prog_clk);
  endtask

  task automatic wait_shifts(input int n, input string tag);
    int t;
    t = 0;
    while (shift_cnt < n && t < BOUND) begin
      @(negedge prog_clk);
      t++;
    end
    if (shift_cnt < n) check({tag, "_shift_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic run_load(input logic [7:0] b0, input logic [7:0] b1, input int gap,
                          input logic [CHAIN_LEN-1:0] prior, input bit inject, input string tag);
    int gap_hi;
    int t;
    begin_load(prior);
    send_byte(b0, 0, tag, gap_hi);
    if (inject) begin
      start = 1'b1;
      @(negedge prog_clk);
      start = 1'b0;
    end
    send_byte(b1, gap, tag, gap_hi);
    bus.s_valid = 1'b0;
    if (gap > 0) check({tag, "_gap_shift_en"}, gap_hi, 0);
    t = 0;
    while (!done && t < BOUND) begin
      @(negedge prog_clk);
      t++;
      // Final shift cycle is the loader's DONE state; start there must be ignored.
      if (inject && ccff_shift_en && shift_cnt == CHAIN_LEN - 1) start = 1'b1;
      if (done) start = 1'b0;
    end
    start = 1'b0;
    if (!done) begin
      check({tag, "_done_timeout"}, 32'd0, 32'd1);
      return;
    end
    @(negedge prog_clk);
    check({tag, "_shift_cnt"}, shift_cnt, CHAIN_LEN);
    check({tag, "_chain"}, chain, exp_chain(b0, b1));
    check({tag, "_done_cnt"}, done_cnt, 1);
    check({tag, "_abort_cnt"}, abort_cnt, 0);
    check({tag, "_crc"}, crc, exp_crc(prior));
    if (inject) begin
      repeat (3) @(negedge prog_clk);
      check({tag, "_start_ignored"}, {busy, bus.s_ready, ccff_shift_en}, 3'b000);
    end else begin
      check({tag, "_idle"}, {busy, done}, 2'b00);
    end
  endtask

  initial begin
    logic [7:0]           rb0, rb1;
    logic [CHAIN_LEN-1:0] rprior;
    int                   gap_hi;

    prog_reset  = 1'b1;
    start       = 1'b0;
    abort       = 1'b0;
    mon_load    = 1'b0;
    mon_prior   = '0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    repeat (3) @(negedge prog_clk);
    check("reset_outs", {bus.s_ready, ccff_head, ccff_shift_en, busy, done, aborted}, 6'b0);
    check("reset_crc", crc, 16'h0000);
    prog_reset = 1'b0;

    // abort in IDLE has no effect
    @(negedge prog_clk);
    abort = 1'b1;
    @(negedge prog_clk);
    abort = 1'b0;
    @(negedge prog_clk);
    check("idle_abort", {aborted, busy, bus.s_ready}, 3'b000);

    run_load(8'hA5, 8'h3C, 0, '0, 1'b0, "t1");
    check("t1_chain_lit", chain, 15'b101001010011110);

    run_load(8'hA5, 8'h3C, 5, '0, 1'b0, "gap");
    check("gap_chain_lit", chain, 15'b101001010011110);

    // abort after 4 shifted bits
    begin_load('0);
    send_byte(8'hF0, 0, "abort", gap_hi);
    bus.s_valid = 1'b0;
    wait_shifts(4, "abort");
    abort = 1'b1;
    @(negedge prog_clk);
    abort = 1'b0;
    check("abort_outs", {ccff_shift_en, aborted, busy, bus.s_ready}, 4'b0100);
    gap_hi = shift_cnt;
    repeat (12) @(negedge prog_clk);
    check("abort_no_more_shift", shift_cnt, gap_hi);
    check("abort_pulse_cnt", abort_cnt, 1);
    check("abort_no_done", done_cnt, 0);

    // start in SHIFT and DONE ignored, then a fresh load
    run_load(8'h5A, 8'hC3, 0, 15'h1234, 1'b1, "inject");
    run_load(8'h96, 8'h69, 0, 15'h7001, 1'b0, "fresh");

    // synchronous reset after 7 bits
    begin_load(15'h2AAA);
    send_byte(8'hFF, 0, "rst", gap_hi);
    wait_shifts(7, "rst");
    prog_reset = 1'b1;
    @(negedge prog_clk);
    check("rst_outs", {bus.s_ready, ccff_head, ccff_shift_en, busy, done, aborted}, 6'b0);
    check("rst_crc", crc, 16'h0000);
    prog_reset  = 1'b0;
    bus.s_valid = 1'b0;
    run_load(8'h81, 8'h7E, 2, 15'h0F0F, 1'b0, "post_rst");

    // readback signature over an all-ones chain
    run_load(8'($urandom), 8'($urandom), 0, '1, 1'b0, "crc_ones");

    for (int it = 0; it < 6; it++) begin
      rb0    = 8'($urandom);
      rb1    = 8'($urandom);
      rprior = CHAIN_LEN'($urandom);
      run_load(rb0, rb1, int'($urandom_range(0, 6)), rprior, 1'b0, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
